companding_expander_mc: RTL

- Multi-channel, handshaked successor to the team's combinational 8-bit-to-linear expander.
- Accepts a frame of NUM_CH 8-bit companded codes in one input handshake.
- Expands each code to OUT_W-bit two's-complement linear PCM using the codebase's existing segment/mantissa mapping.
- Streams the results one channel per beat over a valid/ready output, ahead of the linear-PCM DSP chain.

---
 rtl/companding_expander_mc_if.sv | 28 ++
 rtl/companding_expander_mc.sv | 97 +++++++++
 2 files changed

// File: rtl/companding_expander_mc_if.sv
// Frame-in / beat-out handshake bundle for companding_expander_mc.
// The slave modport is the expander; the master modport is its environment.
interface companding_expander_mc_if #(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 12
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [8*NUM_CH-1:0]   in_frame;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_last;
    logic                  busy;

    modport slave (
        input  in_valid, in_frame, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last, busy
    );

    modport master (
        output in_valid, in_frame, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last, busy
    );
endinterface

// File: rtl/companding_expander_mc.sv
// Multi-channel 8-bit companded to linear PCM expander, one channel per output beat.
// Optional COMPAND_SATURATE_EN clamps magnitudes to the signed OUT_W range instead of wrapping.
module companding_expander_mc #(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    companding_expander_mc_if.slave  io_bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;
    localparam logic [15:0] SAT_MAX = 16'((32'd1 << (OUT_W - 1)) - 32'd1);

    logic [0:0]          r_state;
    logic [8*NUM_CH-1:0] r_frame;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;
    logic [CH_W-1:0]     r_out_ch;
    logic                r_out_last;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_beat;
    logic [CH_W-1:0]     w_next_ch;
    logic [7:0]          w_next_code;

    function automatic logic [OUT_W-1:0] expand(input logic [7:0] c);
        logic [7:0]  m;
        logic [2:0]  seg;
        logic [3:0]  man;
        logic [12:0] step;
        logic [12:0] mag;
        logic [15:0] v;
        m    = c[7] ? 8'(~c + 8'd1) : c;
        seg  = m[6:4];
        man  = m[3:0];
        step = (seg == 3'd0) ? 13'd2 : (13'd1 << seg);
        mag  = step * ({9'd0, man} + 13'd1) + (13'd16 << seg);
        v    = {3'd0, mag};
`ifdef COMPAND_SATURATE_EN
        if (v > SAT_MAX) v = SAT_MAX;
`endif
        if (c[7]) v = ~v + 16'd1;
        return v[OUT_W-1:0];
    endfunction

    // Ready is combinational from out_ready so a new frame overlaps the last beat.
    assign w_in_ready = (r_state == S_IDLE) | (r_out_valid & io_bus.out_ready & r_out_last);
    assign w_accept   = io_bus.in_valid & w_in_ready;
    assign w_beat     = r_out_valid & io_bus.out_ready;
    assign w_next_ch  = r_out_ch + CH_W'(1);

    always_comb begin
        w_next_code = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (k == 32'(w_next_ch)) w_next_code = r_frame[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_frame     <= io_bus.in_frame;
            r_out_data  <= expand(io_bus.in_frame[7:0]);
            r_out_ch    <= '0;
            r_out_last  <= 1'(NUM_CH == 1);
            r_out_valid <= 1'b1;
            r_state     <= S_SEND;
        end else if (w_beat) begin
            if (r_out_last) begin
                r_out_valid <= 1'b0;
                r_out_ch    <= '0;
                r_out_last  <= 1'b0;
                r_state     <= S_IDLE;
            end else begin
                r_out_ch    <= w_next_ch;
                r_out_data  <= expand(w_next_code);
                r_out_last  <= (w_next_ch == CH_W'(NUM_CH - 1));
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_ch    = r_out_ch;
    assign io_bus.out_last  = r_out_last;
    assign io_bus.busy      = (r_state == S_SEND);
endmodule
